// File: rtl/param_universal_counter_pkg.sv
// counter_pkg: boundary-mode encodings shared by the counter family
package counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
endpackage

// File: rtl/param_universal_counter_if.sv
// param_universal_counter_if: control inputs and count outputs of the counter
interface param_universal_counter_if #(parameter int WIDTH = 8);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             up_down_count;
  logic [WIDTH-1:0] max_value;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             done;
  modport master (output en, load, load_value, up_down_count, max_value, mode,
                  input count_out, tc, done);
  modport slave  (input en, load, load_value, up_down_count, max_value, mode,
                  output count_out, tc, done);
endinterface

// File: rtl/param_universal_counter.sv
// param_universal_counter: loadable up/down counter with wrap, saturate and one-shot boundaries
module param_universal_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic clk,
  input logic rst,
  param_universal_counter_if.slave bus
);
  logic             up, at_bnd, clamp;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    up     = bus.up_down_count;
    at_bnd = up ? (bus.count_out >= bus.max_value) : (bus.count_out == '0);
    clamp  = (bus.mode == MODE_SAT) || (bus.mode == MODE_ONESHOT);
    // clamping modes stop at the edge reached; wrap jumps to the opposite edge
    nxt    = !at_bnd ? (up ? bus.count_out + 1'b1 : bus.count_out - 1'b1) :
             (clamp == up) ? bus.max_value : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.count_out <= WIDTH'(RESET_VALUE);
      bus.tc        <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.load) begin
      bus.count_out <= bus.load_value;
      bus.tc        <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.done) begin
      bus.tc        <= 1'b0;
    end else if (bus.en) begin
      bus.count_out <= nxt;
      bus.tc        <= at_bnd;
      bus.done      <= at_bnd && (bus.mode == MODE_ONESHOT);
    end else begin
      bus.tc        <= 1'b0;
    end
  end
endmodule

// File: tb/tb_param_universal_counter.sv
// tb_param_universal_counter: directed checks of the counter at WIDTH=4, RESET_VALUE=3
module tb_param_universal_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  param_universal_counter_if #(.WIDTH(4)) ifc ();
  param_universal_counter #(.WIDTH(4), .RESET_VALUE(3)) dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] c, input logic t, input logic d);
    chk({tag, ".count"}, {4'h0, ifc.count_out}, {4'h0, c});
    chk({tag, ".tc"}, {7'h0, ifc.tc}, {7'h0, t});
    chk({tag, ".done"}, {7'h0, ifc.done}, {7'h0, d});
  endtask
  initial begin
    rst = 1'b1;
    ifc.en = 1'b0; ifc.load = 1'b0; ifc.load_value = '0;
    ifc.up_down_count = 1'b1; ifc.max_value = 4'd9; ifc.mode = 2'b00;
    step();
    chk_all("reset", 4'd3, 1'b0, 1'b0);
    rst = 1'b0; ifc.load = 1'b1; ifc.load_value = 4'd6;
    step();
    chk_all("load6", 4'd6, 1'b0, 1'b0);
    ifc.load_value = 4'd7;
    step();
    ifc.load = 1'b0; ifc.en = 1'b1;
    step(); chk_all("wrap_a", 4'd8, 1'b0, 1'b0);
    step(); chk_all("wrap_b", 4'd9, 1'b0, 1'b0);
    step(); chk_all("wrap_c", 4'd0, 1'b1, 1'b0);
    step(); chk_all("wrap_d", 4'd1, 1'b0, 1'b0);
    ifc.en = 1'b0; ifc.load = 1'b1; ifc.load_value = 4'd2; ifc.mode = 2'b01; ifc.up_down_count = 1'b0;
    step();
    ifc.load = 1'b0; ifc.en = 1'b1;
    step(); chk_all("sat_a", 4'd1, 1'b0, 1'b0);
    step(); chk_all("sat_b", 4'd0, 1'b0, 1'b0);
    step(); chk_all("sat_c", 4'd0, 1'b1, 1'b0);
    step(); chk_all("sat_d", 4'd0, 1'b1, 1'b0);
    step(); chk_all("sat_e", 4'd0, 1'b1, 1'b0);
    ifc.en = 1'b0;
    step(); chk_all("hold", 4'd0, 1'b0, 1'b0);
    ifc.en = 1'b1; ifc.load = 1'b1; ifc.load_value = 4'd3; ifc.max_value = 4'd5;
    ifc.mode = 2'b10; ifc.up_down_count = 1'b1;
    step();
    ifc.load = 1'b0;
    step(); chk_all("os_a", 4'd4, 1'b0, 1'b0);
    step(); chk_all("os_b", 4'd5, 1'b0, 1'b0);
    step(); chk_all("os_c", 4'd5, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ifc.mode = 2'b00;
      step(); chk_all("os_hold", 4'd5, 1'b0, 1'b1);
    end
    ifc.load = 1'b1; ifc.load_value = 4'd2;
    step(); chk_all("os_reload", 4'd2, 1'b0, 1'b0);
    ifc.load_value = 4'd12; ifc.mode = 2'b00;
    step(); chk_all("above_load", 4'd12, 1'b0, 1'b0);
    ifc.load = 1'b0;
    step(); chk_all("above_wrap", 4'd0, 1'b1, 1'b0);
    ifc.load = 1'b1;
    step();
    ifc.load = 1'b0; ifc.up_down_count = 1'b0;
    step(); chk_all("above_dn_a", 4'd11, 1'b0, 1'b0);
    step(); chk_all("above_dn_b", 4'd10, 1'b0, 1'b0);
    ifc.load = 1'b1; ifc.load_value = 4'd8;
    step(); chk_all("load_wins", 4'd8, 1'b0, 1'b0);
    rst = 1'b1;
    step(); chk_all("rst_wins", 4'd3, 1'b0, 1'b0);
    rst = 1'b0; ifc.load = 1'b0; ifc.max_value = 4'd0; ifc.up_down_count = 1'b1;
    step(); chk_all("max0_a", 4'd0, 1'b1, 1'b0);
    step(); chk_all("max0_b", 4'd0, 1'b1, 1'b0);
    ifc.up_down_count = 1'b0;
    step(); chk_all("max0_dn", 4'd0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
